mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the shared-memory variant of the ARM-like CPU. It sequences a datapath that has one unified instruction/data memory port, an instruction register and a single ALU used for PC increment, address generation and execution. It decodes Instr[31:12], holds the NZCV condition flags, evaluates condition codes and drives every datapath enable and mux select cycle by cycle. It replaces the single-cycle `controller` in a `cpu_mc` top.

## Interface
Parameters: none.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  IR bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]; stable from the cycle after FETCH
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=RD1 (Rn), 01=PC
- ALUSrcB  out  2  00=RD2 (Rm), 01=ExtImm, 10=constant 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- RegWrite  out  1  register file write enable

## Operation
- Moore FSM, 10 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALU ADD, ResultSrc=10, PCWrite=1 (PC+4) → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (computes PC+8). Latch CondExR. Op=01→MEMADR; Op=00,Funct[5]=0→EXECR; Op=00,Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (undefined, no side effects).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Funct[0]=1→MEMREAD, else→MEMWRITE.
- MEMREAD: AdrSrc=1 → MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExR → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondExR → FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00. EXECI: ALUSrcA=00, ALUSrcB=01. ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write); others ADD. Both → ALUWB.
- ALUWB: ResultSrc=00; RegWrite=CondExR & ~CMP & (Rd≠15); if Rd==15, PCWrite=CondExR instead → FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR → FETCH.
- Flags: in EXECR/EXECI, if Funct[0] (S) or CMP, and CondExR: N,Z always updated; C,V only for ADD/SUB/CMP. LDR/STR/B never update flags.
- Condition codes EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL evaluated on stored flags; 1111 → false.
- All outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, flags=0000, CondExR=0; PCWrite, IRWrite, MemWrite, RegWrite forced 0 while reset=1. First fetch in cycle after reset deasserts.
- CPI: LDR 5, STR 4, data-processing 4, B 3, undefined 2.
- Outputs depend only on state, Instr, CondExR (no ALUFlags path to outputs).
- CondExR latched at end of DECODE; flag update at end of EXEC cycle affects only the next instruction.
- Failed condition: state sequence unchanged, all writes suppressed, PC advances by 4 only.
- Reset mid-instruction: aborts next cycle, no pending write issued.

## Structure
- Package mc_pkg: state enum, Op encodings (DP=00, MEM=01, BR=10), Funct cmd codes, ALUControl/ResultSrc/ALUSrc constants, cond code constants.
- Sub-module mc_cond_unit: flags register, condition evaluation, flag-write gating.

## Test plan
- Reset held 2 cycles, release → state FETCH, IRWrite=1, PCWrite=1, flags=0000.
- ADD R1,R2,R3 (Instr=0xE0821) → states F,D,EXECR,ALUWB; RegWrite=1 only in ALUWB, ALUControl=00.
- LDR R1,[R2,#4] (0xE5921) → 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01, RegWrite=1 in MEMWB. STR (0xE5821) → MemWrite=1 in 4th cycle only.
- SUBS R0,R0,R0 (0xE0500) with ALUFlags=0100 → Z set; next ADDNE (0x10821) → RegWrite stays 0; ADDEQ (0x00821) → RegWrite=1.
- B (0xEA000) → 3 cycles, PCWrite=1 in BRANCH; BNE with Z=1 → PCWrite=0 in BRANCH.
- Op=11 (0xEC000) → FETCH after DECODE, no writes; reset asserted during MEMWRITE → MemWrite=0, state FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// fields, datapath mux/ALU selects and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_RN = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Unlisted data-processing commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      CMD_CMP: alu_decode = ALU_SUB;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// NZCV flag register, condition-code evaluation and the latched per-instruction
// execute decision (condexr) that gates every architectural write.
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       latch_cond,
  input  logic       flag_wr_nz,
  input  logic       flag_wr_cv,
  output logic       condexr,
  output logic [3:0] flags
);

  logic n, z, c, v;
  logic cond_ok;
  logic nz_we, cv_we;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // A failed condition must leave the flags untouched.
  assign nz_we = flag_wr_nz & condexr;
  assign cv_we = flag_wr_cv & condexr;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags   <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      if (latch_cond) condexr <= cond_ok;
      if (nz_we) flags[3:2] <= aluflags[3:2];
      if (cv_we) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing a shared-memory datapath,
// with condition evaluation and flag storage delegated to mc_cond_unit.
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output state_t      dbg_state,
  output logic [3:0]  dbg_flags
);

  state_t     state;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic [1:0] alu_dp;
  logic       is_cmp;
  logic       in_exec;
  logic       flag_wr_nz, flag_wr_cv;
  logic       condexr;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign cmd       = funct[4:1];
  assign alu_dp    = alu_decode(cmd);
  assign is_cmp    = (cmd == CMD_CMP);
  assign in_exec   = (state == S_EXECR) || (state == S_EXECI);

  // S-bit or CMP requests a flag update; C/V only come from arithmetic ops.
  assign flag_wr_nz = in_exec & (funct[0] | is_cmp);
  assign flag_wr_cv = flag_wr_nz & ((alu_dp == ALU_ADD) || (alu_dp == ALU_SUB));

  mc_cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .aluflags   (ALUFlags),
    .latch_cond (state == S_DECODE),
    .flag_wr_nz (flag_wr_nz),
    .flag_wr_cv (flag_wr_cv),
    .condexr    (condexr),
    .flags      (dbg_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= funct[5] ? S_EXECI : S_EXECR;
            OP_BR:   state <= S_BRANCH;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: state <= S_MEMWB;
        S_EXECR:   state <= S_ALUWB;
        S_EXECI:   state <= S_ALUWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  assign dbg_state = state;
  assign ImmSrc    = op;
  assign RegSrc    = {op == OP_MEM, op == OP_BR};

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_RN;
    ALUSrcB    = SRCB_RM;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = condexr;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = condexr;
      end
      S_EXECR:    ALUControl = alu_dp;
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dp;
      end
      // Rd==15 redirects the writeback into the PC.
      S_ALUWB: begin
        if (rd == 4'd15) PCWrite  = condexr & ~is_cmp;
        else             RegWrite = condexr & ~is_cmp;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = condexr;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle's expected control word is
// queued by the driver and compared by an independent negedge monitor.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int W = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'b1011;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  state_t      dbg_state;
  logic [3:0]  dbg_flags;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .dbg_state  (dbg_state),
    .dbg_flags  (dbg_flags)
  );

  logic [W-1:0] obs;
  assign obs = {dbg_state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, dbg_flags};

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  logic        nxt_reset = 1'b1;
  logic [19:0] nxt_instr = 20'h0;
  logic [3:0]  nxt_flags = 4'b1011;
  logic [3:0]  exp_flags = 4'b0000;
  logic [3:0]  exp_ir = 4'b0000;
  string       cur_name = "reset";

  // Driver: apply inputs just after the edge, queue that cycle's expected word.
  task automatic step(input state_t st, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] ac, input logic rw);
    @(posedge clk);
    #1;
    reset    = nxt_reset;
    Instr    = nxt_instr;
    ALUFlags = nxt_flags;
    exp_q.push_back({st, pcw, adr, mw, irw, rs, sa, sb, ac, exp_ir, rw, exp_flags});
    name_q.push_back($sformatf("%s/%s", cur_name, st.name()));
  endtask

  task automatic start(input string n, input logic [19:0] ins, input logic [3:0] ir);
    cur_name  = n;
    nxt_instr = ins;
    exp_ir    = ir;
  endtask

  task automatic c_fetch();       step(S_FETCH,    1, 0, 0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 0); endtask
  task automatic c_decode();      step(S_DECODE,   0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0); endtask
  task automatic c_memadr();      step(S_MEMADR,   0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0); endtask
  task automatic c_memread();     step(S_MEMREAD,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); endtask
  task automatic c_memwb(input logic rw);    step(S_MEMWB,    0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, rw); endtask
  task automatic c_memwrite(input logic mw); step(S_MEMWRITE, 0, 1, mw, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0); endtask
  task automatic c_execr(input logic [1:0] ac); step(S_EXECR, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ac, 0); endtask
  task automatic c_execi(input logic [1:0] ac); step(S_EXECI, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, ac, 0); endtask
  task automatic c_aluwb(input logic pcw, input logic rw); step(S_ALUWB, pcw, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, rw); endtask
  task automatic c_branch(input logic pcw);  step(S_BRANCH,   pcw, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0); endtask

  // Monitor: every cycle presents a control word; compare against the queue head.
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, obs, e);
        end
      end
    end
  end

  initial begin
    // Second reset cycle: state already FETCH, writes held off, flags clear.
    nxt_reset = 1'b1;
    step(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0);
    nxt_reset = 1'b0;

    start("add", 20'hE0821, 4'b0000);
    c_fetch(); c_decode(); c_execr(2'b00); c_aluwb(0, 1);

    start("orr_imm", 20'hE3811, 4'b0000);
    c_fetch(); c_decode(); c_execi(2'b11); c_aluwb(0, 1);

    start("add_pc", 20'hE082F, 4'b0000);
    c_fetch(); c_decode(); c_execr(2'b00); c_aluwb(1, 0);

    start("ldr", 20'hE5921, 4'b0110);
    c_fetch(); c_decode(); c_memadr(); c_memread(); c_memwb(1);

    start("str", 20'hE5821, 4'b0110);
    c_fetch(); c_decode(); c_memadr(); c_memwrite(1);

    start("subs", 20'hE0500, 4'b0000);
    c_fetch(); c_decode();
    nxt_flags = 4'b0100;
    c_execr(2'b01);
    nxt_flags = 4'b1011;
    exp_flags = 4'b0100;
    c_aluwb(0, 1);

    start("addne", 20'h10821, 4'b0000);
    c_fetch(); c_decode(); c_execr(2'b00); c_aluwb(0, 0);

    start("addeq", 20'h00821, 4'b0000);
    c_fetch(); c_decode(); c_execr(2'b00); c_aluwb(0, 1);

    start("b", 20'hEA000, 4'b1001);
    c_fetch(); c_decode(); c_branch(1);

    start("bne", 20'h1A000, 4'b1001);
    c_fetch(); c_decode(); c_branch(0);

    start("undef", 20'hEC000, 4'b1100);
    c_fetch(); c_decode();

    start("str_abort", 20'hE5821, 4'b0110);
    c_fetch(); c_decode(); c_memadr();
    nxt_reset = 1'b1;
    c_memwrite(0);
    nxt_reset = 1'b0;
    exp_flags = 4'b0000;
    c_fetch();

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
